// File: rtl/nischal_arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nischal_arith_pkg
//  Brief    : Shared types for the nischal_arith_seq arithmetic engine:
//             operation codes, control FSM states and the FIFO entry layout.
//  Revision : 1.0 - initial release
// ============================================================================
package nischal_arith_pkg;

    // Operation select, encoded exactly as driven on the op port
    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_MUL = 2'b11
    } op_e;

    // Control FSM: single-cycle ops complete in IDLE, MUL walks RUN -> WB
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_MUL_RUN = 2'b01,
        ST_MUL_WB  = 2'b10
    } state_e;

    // FIFO entry is {carry, result}; the carry flag always sits in the MSB
    localparam int c_ENTRY_FLAG_BITS = 1;

endpackage
`default_nettype wire

// File: rtl/nischal_arith_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : nischal_arith_fifo
//  Brief    : Synchronous FIFO holding {carry, result} entries. DEPTH must be
//             a power of two so the pointers wrap naturally.
//  Revision : 1.0 - initial release
// ============================================================================
module nischal_arith_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL  = DEPTH[c_PTR_W:0];

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    assign full      = (r_count == c_FULL);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign pop_data  = r_mem[r_rd_ptr];

    // Storage write; contents need no reset because empty masks them
    always_ff @(posedge clk) begin
        if (rst_n && w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop together leave count unchanged
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/nischal_arith_seq.sv
`default_nettype none
// ============================================================================
//  Module   : nischal_arith_seq
//  Brief    : Sequential arithmetic engine (ADD, SUB, running ACC, iterative
//             shift-add MUL) with results queued in an output FIFO behind
//             valid/ready handshakes.
//             Optional: NISCHAL_ARITH_SAT_EN enables unsigned saturation of
//             pushed results (overflow -> all ones, borrow -> zero).
//  Revision : 1.0 - initial release
// ============================================================================
module nischal_arith_seq
    import nischal_arith_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             op,
    input  logic [W-1:0]           a,
    input  logic [W-1:0]           b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           result,
    output logic                   carry,
    output logic [$clog2(DEPTH):0] out_count
);

    localparam int                 c_CNT_W     = $clog2(W);
    localparam logic [c_CNT_W-1:0] c_LAST_STEP = c_CNT_W'(W - 1);

    state_e             r_state;
    state_e             w_state_nxt;
    op_e                w_op;
    logic [W-1:0]       r_acc;
    logic [W-1:0]       w_acc_nxt;
    logic [2*W-1:0]     r_prod;
    logic [2*W-1:0]     r_mcand;
    logic [W-1:0]       r_mplier;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [W:0]         w_push_data;
    logic [W:0]         w_head;

    logic [W:0]         w_add_sum;
    logic [W:0]         w_acc_sum;
    logic               w_borrow;
    logic               w_mul_ovf;
    logic [W-1:0]       w_add_res;
    logic [W-1:0]       w_sub_res;
    logic [W-1:0]       w_acc_res;
    logic [W-1:0]       w_mul_res;

    assign w_op      = op_e'(op);
    assign in_ready  = rst_n & ena & (r_state == ST_IDLE) & ~w_full;
    assign w_accept  = in_valid & in_ready;

    assign w_add_sum = {1'b0, a} + {1'b0, b};
    assign w_acc_sum = {1'b0, (b[0] ? {W{1'b0}} : r_acc)} + {1'b0, a};
    assign w_borrow  = (a < b);
    assign w_mul_ovf = |r_prod[2*W-1:W];

`ifdef NISCHAL_ARITH_SAT_EN
    assign w_add_res = w_add_sum[W] ? {W{1'b1}} : w_add_sum[W-1:0];
    assign w_sub_res = w_borrow     ? {W{1'b0}} : (a - b);
    assign w_acc_res = w_acc_sum[W] ? {W{1'b1}} : w_acc_sum[W-1:0];
    assign w_mul_res = w_mul_ovf    ? {W{1'b1}} : r_prod[W-1:0];
`else
    assign w_add_res = w_add_sum[W-1:0];
    assign w_sub_res = a - b;
    assign w_acc_res = w_acc_sum[W-1:0];
    assign w_mul_res = r_prod[W-1:0];
`endif

    // Next-state and push decode; single-cycle ops push on acceptance, MUL pushes from WB
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_push      = 1'b0;
        w_push_data = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (w_op)
                        OP_ADD: begin
                            w_push      = 1'b1;
                            w_push_data = {w_add_sum[W], w_add_res};
                        end
                        OP_SUB: begin
                            w_push      = 1'b1;
                            w_push_data = {w_borrow, w_sub_res};
                        end
                        OP_ACC: begin
                            w_push      = 1'b1;
                            w_push_data = {w_acc_sum[W], w_acc_res};
                            w_acc_nxt   = w_acc_res;
                        end
                        OP_MUL: begin
                            w_state_nxt = ST_MUL_RUN;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL_RUN: begin
                if (r_cnt == c_LAST_STEP) w_state_nxt = ST_MUL_WB;
            end
            ST_MUL_WB: begin
                // Waits here while the FIFO is full; ena gates the push itself
                if (ena && !w_full) begin
                    w_push      = 1'b1;
                    w_push_data = {w_mul_ovf, w_mul_res};
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, accumulator and shift-add multiplier registers; ena=0 freezes everything
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_acc    <= '0;
            r_prod   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (ena) begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            if (r_state == ST_IDLE && w_accept && w_op == OP_MUL) begin
                r_prod   <= '0;
                r_mcand  <= {{W{1'b0}}, a};
                r_mplier <= b;
                r_cnt    <= '0;
            end else if (r_state == ST_MUL_RUN) begin
                if (r_mplier[0]) r_prod <= r_prod + r_mcand;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    assign w_pop     = out_valid & out_ready;
    assign out_valid = ena & ~w_empty;
    // Head is masked to zero when empty so reset shows result=0, carry=0
    assign {carry, result} = w_empty ? {(W + 1){1'b0}} : w_head;

    nischal_arith_fifo #(
        .WIDTH (W + c_ENTRY_FLAG_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .pop_data  (w_head),
        .count     (out_count),
        .full      (w_full),
        .empty     (w_empty)
    );

endmodule
`default_nettype wire
